jk_ff_bank: RTL

Parametrised, multi-bit successor to the single JK flip-flop. WIDTH JK flops share one clock and reset. A mode input configures them as independent JK cells, a synchronous up-counter, a synchronous down-counter, or a serial shift register. Intended as the general-purpose sequential register and counter element in the Sequential_Ckt library.

---
 rtl/jk_ff_bank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH JK flops behind one clock, usable as JK cells, up/down counter or shift register.
// Define JK_FF_BANK_SAT_EN to make the count modes saturate instead of wrapping.
module jk_ff_bank #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  mode_e            modeSel;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] onesBelow;
  logic [WIDTH-1:0] zerosBelow;
  logic [WIDTH-1:0] shiftSrc;
  logic [WIDTH-1:0] jEff;
  logic [WIDTH-1:0] kEff;
  logic [WIDTH-1:0] jkNext;
  logic             allOnes;
  logic             allZeros;
  logic             upHold;
  logic             downHold;

  assign modeSel  = mode_e'(mode);
  assign shiftSrc = {q_q[WIDTH-2:0], j[0]};

  // Ripple of "all lower bits are 1/0": the toggle condition of each counter stage.
  always_comb begin : prefixChain
    logic onesAcc;
    logic zerosAcc;
    onesAcc    = 1'b1;
    zerosAcc   = 1'b1;
    onesBelow  = '0;
    zerosBelow = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onesBelow[i]  = onesAcc;
      zerosBelow[i] = zerosAcc;
      onesAcc       = onesAcc & q_q[i];
      zerosAcc      = zerosAcc & ~q_q[i];
    end
    allOnes  = onesAcc;
    allZeros = zerosAcc;
  end

`ifdef JK_FF_BANK_SAT_EN
  assign upHold   = allOnes;
  assign downHold = allZeros;
`else
  assign upHold   = 1'b0;
  assign downHold = 1'b0;
`endif

  // Every mode is expressed as J/K drive so all bits share the same JK cell update.
  always_comb begin
    jEff = '0;
    kEff = '0;
    case (modeSel)
      MODE_JK: begin
        jEff = j;
        kEff = k;
      end
      MODE_UP: begin
        if (!upHold) begin
          jEff = onesBelow;
          kEff = onesBelow;
        end
      end
      MODE_DOWN: begin
        if (!downHold) begin
          jEff = zerosBelow;
          kEff = zerosBelow;
        end
      end
      MODE_SHIFT: begin
        jEff = shiftSrc;
        kEff = ~shiftSrc;
      end
      default: begin
        jEff = '0;
        kEff = '0;
      end
    endcase
  end

  always_comb begin
    jkNext = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({jEff[i], kEff[i]})
        2'b00:   jkNext[i] = q_q[i];
        2'b01:   jkNext[i] = 1'b0;
        2'b10:   jkNext[i] = 1'b1;
        default: jkNext[i] = ~q_q[i];
      endcase
    end
  end

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = jkNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;
  assign tc = ((modeSel == MODE_UP) && allOnes) || ((modeSel == MODE_DOWN) && allZeros);

endmodule
